// File: rtl/universal_shift_reg_burst.sv
`default_nettype none
// ============================================================================
// Module   : universal_shift_reg_burst
// Brief    : Parametrised universal shift register with an autonomous burst engine
// Revision : 1.0 - initial release
// ============================================================================
module universal_shift_reg_burst #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] inp,
    input  logic             ser_in_lsb,
    input  logic             ser_in_msb,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] out,
    output logic             ser_out_lsb,
    output logic             ser_out_msb,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [2:0] c_HOLD = 3'b000;
    localparam logic [2:0] c_SHL  = 3'b001;
    localparam logic [2:0] c_SHR  = 3'b010;
    localparam logic [2:0] c_LOAD = 3'b011;
    localparam logic [2:0] c_ROL  = 3'b100;
    localparam logic [2:0] c_ROR  = 3'b101;
    localparam logic [2:0] c_ASR  = 3'b110;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_run_mode, w_run_mode_nxt;
    logic [CNT_W-1:0] r_remaining, w_remaining_nxt;
    logic [WIDTH-1:0] r_out, w_out_nxt;
    logic             r_done, w_done_nxt;
    logic [2:0]       w_op_mode;
    logic [WIDTH-1:0] w_op_result;

    // In RUN the latched burst mode drives the datapath; live mode is ignored.
    assign w_op_mode = (r_state == S_RUN) ? r_run_mode : mode;

    always_comb begin
        w_op_result = '0;
        case (w_op_mode)
            c_HOLD:  w_op_result = r_out;
            c_SHL:   w_op_result = {r_out[WIDTH-2:0], ser_in_lsb};
            c_SHR:   w_op_result = {ser_in_msb, r_out[WIDTH-1:1]};
            c_LOAD:  w_op_result = inp;
            c_ROL:   w_op_result = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
            c_ROR:   w_op_result = {r_out[0], r_out[WIDTH-1:1]};
            c_ASR:   w_op_result = {r_out[WIDTH-1], r_out[WIDTH-1:1]};
            default: w_op_result = '0;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_out_nxt       = r_out;
        w_run_mode_nxt  = r_run_mode;
        w_remaining_nxt = r_remaining;
        w_done_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_run_mode_nxt  = mode;
                    w_remaining_nxt = count;
                    if (count != '0) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end else if (en) begin
                    w_out_nxt = w_op_result;
                end
            end
            S_RUN: begin
                if (en) begin
                    w_out_nxt       = w_op_result;
                    w_remaining_nxt = r_remaining - 1'b1;
                    if (r_remaining == CNT_W'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_out       <= '0;
            r_run_mode  <= 3'b000;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out       <= w_out_nxt;
            r_run_mode  <= w_run_mode_nxt;
            r_remaining <= w_remaining_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign out         = r_out;
    assign ser_out_lsb = r_out[0];
    assign ser_out_msb = r_out[WIDTH-1];
    assign busy        = (r_state == S_RUN);
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_reg_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_universal_shift_reg_burst
// Brief    : Directed vector bench for the universal shift register burst engine
// Revision : 1.0 - initial release
// ============================================================================
module tb_universal_shift_reg_burst;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] inp;
    logic             ser_in_lsb;
    logic             ser_in_msb;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] out;
    logic             ser_out_lsb;
    logic             ser_out_msb;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    universal_shift_reg_burst #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .mode        (mode),
        .inp         (inp),
        .ser_in_lsb  (ser_in_lsb),
        .ser_in_msb  (ser_in_msb),
        .start       (start),
        .count       (count),
        .out         (out),
        .ser_out_lsb (ser_out_lsb),
        .ser_out_msb (ser_out_msb),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst_n;
        logic       en;
        logic       start;
        logic [2:0] mode;
        logic [7:0] inp;
        logic       sl;
        logic       sm;
        logic [3:0] cnt;
        logic [7:0] exp_out;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic r, logic e, logic s, logic [2:0] m,
                                logic [7:0] d, logic sl, logic sm, logic [3:0] c,
                                logic [7:0] eo, logic eb, logic ed);
        vec_t v;
        v.name = n; v.rst_n = r; v.en = e; v.start = s; v.mode = m; v.inp = d;
        v.sl = sl; v.sm = sm; v.cnt = c; v.exp_out = eo; v.exp_busy = eb; v.exp_done = ed;
        return v;
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic r, input logic e, input logic s, input logic [2:0] m,
                       input logic [7:0] d, input logic sl, input logic sm, input logic [3:0] c);
        reset = r; en = e; start = s; mode = m; inp = d;
        ser_in_lsb = sl; ser_in_msb = sm; count = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [7:0] eo, input logic eb, input logic ed);
        checks++;
        if (out !== eo || busy !== eb || done !== ed ||
            ser_out_lsb !== eo[0] || ser_out_msb !== eo[7]) begin
            failures++;
            $display("FAIL %s: got out=%02h busy=%b done=%b lsb=%b msb=%b, want out=%02h busy=%b done=%b",
                     n, out, busy, done, ser_out_lsb, ser_out_msb, eo, eb, ed);
        end
    endtask

    task automatic step(input string n, input logic e, input logic s, input logic [2:0] m,
                        input logic [7:0] d, input logic sl, input logic [3:0] c,
                        input logic [7:0] eo, input logic eb, input logic ed);
        cyc(1'b1, e, s, m, d, sl, 1'b0, c);
        chk(n, eo, eb, ed);
    endtask

    initial begin
        logic [7:0] rol_exp;

        // Reset with random inputs, then single-step modes.
        vecs.push_back(mk("rst0", 0, 1, 1, 3'($urandom), 8'($urandom), 1, 1, 4'd3, 8'h00, 0, 0));
        vecs.push_back(mk("rst1", 0, 1, 0, 3'b011, 8'hFF, 1, 1, 4'd7, 8'h00, 0, 0));
        vecs.push_back(mk("load_a5", 1, 1, 0, 3'b011, 8'hA5, 0, 0, 0, 8'hA5, 0, 0));
        vecs.push_back(mk("rol",     1, 1, 0, 3'b100, 8'h00, 0, 0, 0, 8'h4B, 0, 0));
        vecs.push_back(mk("ror",     1, 1, 0, 3'b101, 8'h00, 0, 0, 0, 8'hA5, 0, 0));
        vecs.push_back(mk("hold",    1, 1, 0, 3'b000, 8'h33, 1, 1, 0, 8'hA5, 0, 0));
        vecs.push_back(mk("load_96", 1, 1, 0, 3'b011, 8'h96, 0, 0, 0, 8'h96, 0, 0));
        vecs.push_back(mk("asr",     1, 1, 0, 3'b110, 8'h00, 0, 0, 0, 8'hCB, 0, 0));
        vecs.push_back(mk("load_96b",1, 1, 0, 3'b011, 8'h96, 0, 0, 0, 8'h96, 0, 0));
        vecs.push_back(mk("shr_m1",  1, 1, 0, 3'b010, 8'h00, 0, 1, 0, 8'hCB, 0, 0));
        vecs.push_back(mk("shr_m0",  1, 1, 0, 3'b010, 8'h00, 1, 0, 0, 8'h65, 0, 0));
        vecs.push_back(mk("load_80", 1, 1, 0, 3'b011, 8'h80, 0, 0, 0, 8'h80, 0, 0));
        vecs.push_back(mk("shl_l1",  1, 1, 0, 3'b001, 8'h00, 1, 0, 0, 8'h01, 0, 0));
        vecs.push_back(mk("clr",     1, 1, 0, 3'b111, 8'hFF, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk("load_5a", 1, 1, 0, 3'b011, 8'h5A, 0, 0, 0, 8'h5A, 0, 0));
        vecs.push_back(mk("en0_load",1, 0, 0, 3'b011, 8'hFF, 0, 0, 0, 8'h5A, 0, 0));

        foreach (vecs[i]) begin
            cyc(vecs[i].rst_n, vecs[i].en, vecs[i].start, vecs[i].mode, vecs[i].inp,
                vecs[i].sl, vecs[i].sm, vecs[i].cnt);
            chk(vecs[i].name, vecs[i].exp_out, vecs[i].exp_busy, vecs[i].exp_done);
        end

        // SHL burst of 3 with ser_in_lsb=0.
        step("b1_load",   1, 0, 3'b011, 8'h01, 0, 0, 8'h01, 0, 0);
        step("b1_accept", 1, 1, 3'b001, 8'h00, 0, 3, 8'h01, 1, 0);
        step("b1_s1",     1, 0, 3'b111, 8'hFF, 0, 0, 8'h02, 1, 0);
        step("b1_s2",     1, 0, 3'b011, 8'hFF, 0, 0, 8'h04, 1, 0);
        step("b1_s3",     1, 0, 3'b000, 8'hFF, 0, 0, 8'h08, 0, 1);
        step("b1_after",  0, 0, 3'b000, 8'h00, 0, 0, 8'h08, 0, 0);

        // ROR burst of 4 with a two-cycle stall and ignored start/mode in RUN.
        step("b2_load",   1, 0, 3'b011, 8'h01, 0, 0, 8'h01, 0, 0);
        step("b2_accept", 1, 1, 3'b101, 8'h00, 0, 4, 8'h01, 1, 0);
        step("b2_s1",     1, 0, 3'b111, 8'h00, 0, 0, 8'h80, 1, 0);
        step("b2_s2",     1, 1, 3'b011, 8'hFF, 0, 9, 8'h40, 1, 0);
        step("b2_stall1", 0, 1, 3'b111, 8'hFF, 0, 9, 8'h40, 1, 0);
        step("b2_stall2", 0, 0, 3'b001, 8'hFF, 1, 0, 8'h40, 1, 0);
        step("b2_s3",     1, 1, 3'b011, 8'hFF, 0, 2, 8'h20, 1, 0);
        step("b2_s4",     1, 0, 3'b100, 8'h00, 0, 0, 8'h10, 0, 1);
        step("b2_after1", 0, 0, 3'b000, 8'h00, 0, 0, 8'h10, 0, 0);
        step("b2_after2", 0, 0, 3'b000, 8'h00, 0, 0, 8'h10, 0, 0);

        // count=0: done pulse, never busy, out unchanged.
        step("c0_accept", 1, 1, 3'b111, 8'h00, 0, 0, 8'h10, 0, 1);
        step("c0_after",  0, 0, 3'b111, 8'h00, 0, 0, 8'h10, 0, 0);

        // Maximum burst: ROL x15 on 0x01, then a new burst started in the done cycle.
        step("c15_load",   1, 0, 3'b011, 8'h01, 0, 0, 8'h01, 0, 0);
        step("c15_accept", 1, 1, 3'b100, 8'h00, 0, 15, 8'h01, 1, 0);
        rol_exp = 8'h01;
        for (int k = 1; k <= 15; k++) begin
            rol_exp = {rol_exp[6:0], rol_exp[7]};
            step($sformatf("c15_s%0d", k), 1, 0, 3'b000, 8'h00, 0, 0, rol_exp,
                 (k != 15), (k == 15));
        end
        step("c15_final",  1, 1, 3'b101, 8'h00, 0, 2, 8'h80, 1, 0);
        step("b2b_s1",     1, 0, 3'b000, 8'h00, 0, 0, 8'h40, 1, 0);
        step("b2b_s2",     1, 0, 3'b000, 8'h00, 0, 0, 8'h20, 0, 1);

        // Reset mid-burst aborts without a done pulse and returns to IDLE.
        step("ab_accept",  1, 1, 3'b100, 8'h00, 0, 5, 8'h20, 1, 0);
        step("ab_s1",      1, 0, 3'b000, 8'h00, 0, 0, 8'h40, 1, 0);
        cyc(1'b0, 1'b1, 1'b1, 3'b011, 8'hFF, 1'b1, 1'b1, 4'd5);
        chk("ab_reset", 8'h00, 0, 0);
        step("ab_post1",   0, 0, 3'b000, 8'h00, 0, 0, 8'h00, 0, 0);
        step("ab_post2",   0, 0, 3'b000, 8'h00, 0, 0, 8'h00, 0, 0);
        step("ab_idle_op", 1, 0, 3'b001, 8'h00, 1, 0, 8'h01, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/universal_shift_reg_burst.md
Name: universal_shift_reg_burst

Overview:
- Parametrised successor to the 4-bit universal shift register.
- Features:
  - Generic width.
  - Eight operating modes: hold, logical shift left/right, load, rotate left/right, arithmetic shift right, clear.
  - Serial taps at both ends.
  - Autonomous burst engine: executes a latched mode N times back-to-back with a busy/done handshake.
- Used as the shift/serialiser datapath stage feeding serial links and bit-manipulation logic.

Parameters:
- WIDTH, 8: register width in bits (minimum 2).
- CNT_W, 4: burst count width; maximum burst length is 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- en  input  1  operation enable; in burst mode, a stall when 0.
- mode  input  3  operation select (encoding below).
- inp  input  WIDTH  parallel load data.
- ser_in_lsb  input  1  bit shifted into out[0] on shift left.
- ser_in_msb  input  1  bit shifted into out[WIDTH-1] on logical shift right.
- start  input  1  burst request (single-cycle pulse or level; sampled only in IDLE).
- count  input  CNT_W  burst length, sampled with start.
- out  output  WIDTH  register contents.
- ser_out_lsb  output  1  combinational tap of out[0].
- ser_out_msb  output  1  combinational tap of out[WIDTH-1].
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset: reset==0 at posedge clk gives:
  - out=0, busy=0, done=0, state=IDLE, remaining count=0.
  - Reset has priority over every other input, including mid-burst; an aborted burst produces no done pulse.
- Mode encoding (new value of out):
  - 000 hold.
  - 001 SHL: {out[WIDTH-2:0], ser_in_lsb}.
  - 010 SHR: {ser_in_msb, out[WIDTH-1:1]}.
  - 011 LOAD: inp.
  - 100 ROL: {out[WIDTH-2:0], out[WIDTH-1]}.
  - 101 ROR: {out[0], out[WIDTH-1:1]}.
  - 110 ASR: {out[WIDTH-1], out[WIDTH-1:1]}.
  - 111 CLR: 0.
- FSM states: IDLE, RUN.
- IDLE, start=0:
  - en=1 applies mode to out at the edge (single-step operation, latency 1 cycle).
  - en=0 holds out.
- IDLE, start=1 (en is ignored on this edge):
  - Acceptance edge: latch mode into run_mode and count into remaining; out is unchanged.
  - count!=0: go to RUN, busy=1 from this edge.
  - count==0: stay IDLE, done=1 for exactly one cycle, busy stays 0.
- RUN:
  - Each edge with en=1: apply run_mode to out and decrement remaining.
  - Each edge with en=0: stall; out and remaining hold and busy stays 1.
  - On the edge that applies the last operation (remaining==1): return to IDLE, busy=0, done=1 for one cycle.
  - A burst of count N therefore changes out on N enabled edges after the acceptance edge.
- RUN input handling:
  - mode, inp and start are ignored; a start during RUN is dropped, not queued.
  - ser_in_lsb and ser_in_msb are sampled live every operation edge.
- LOAD or CLR in a burst repeats the same result each step (legal, no special case).
- done is never high while busy is high.
- A start in the done cycle is accepted normally, so back-to-back bursts are possible.
- ser_out_lsb / ser_out_msb always reflect the current out; there is no extra register stage.

Test Plan (WIDTH=8, CNT_W=4):
- Reset: drive reset=0 with random inputs for 2 cycles -> out=0x00, busy=0, done=0; assert reset=0 mid-burst -> next edge out=0x00, busy=0, no done pulse.
- Single-step modes: LOAD 0xA5 -> 0xA5; ROL -> 0x4B; ROR -> 0xA5; ASR on 0x96 -> 0xCB; SHR with ser_in_msb=1 on 0x96 -> 0xCB; SHL with ser_in_lsb=1 on 0x80 -> 0x01; CLR -> 0x00; en=0 with mode=011 -> out unchanged.
- Burst: out=0x01, start=1, mode=001, count=3, ser_in_lsb=0, en=1 -> accept edge busy=1, out 0x01; next edges out=0x02, 0x04, 0x08; busy falls with the 0x08 edge; done=1 for exactly that following cycle.
- Burst stall and ignore: ROR burst count=4 on 0x01 with en=0 for 2 cycles after the 2nd step, plus start/mode toggling during RUN -> sequence 0x80, 0x40, (hold 2 cycles), 0x20, 0x10; busy held through the stall; only one done pulse.
- Boundaries:
  - count=0 -> done pulse the next cycle, busy never high, out unchanged.
  - count=15 ROL on 0x01 -> out=0x80 after 15 steps.
  - start in the done cycle -> new burst accepted.
